// File: rtl/cmd_dispatch.sv
// Trace command dispatcher: a FIFO with decoded outputs and a CLR handshake toward the cache controller.
// Optional dispatch statistics are built only when CMD_STATS_EN is defined.
module cmd_dispatch #(
    parameter int DEPTH      = 4,
    parameter int I_SIZE     = 32,
    parameter int D_SIZE     = 6,
    parameter int INDEX_BITS = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [3:0]                           in_cmd,
    input  logic [I_SIZE-1:0]                    in_addr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [3:0]                           out_cmd,
    output logic [I_SIZE-INDEX_BITS-D_SIZE-1:0]  out_tag,
    output logic [INDEX_BITS-1:0]                out_index,
    output logic [D_SIZE-1:0]                    out_byte,
    output logic                                 out_snoop,
    input  logic                                 clr_done,
    output logic                                 bad_cmd,
    output logic [31:0]                          rd_cnt,
    output logic [31:0]                          wr_cnt,
    output logic [31:0]                          snp_cnt
);

    localparam int TAG_W = I_SIZE - INDEX_BITS - D_SIZE;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 4 + I_SIZE;
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {RUN, WAIT_CLR} state_t;

    state_t            state_q, state_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              bad_cmd_q;

    logic              full, empty, accept, legal, push, pop;
    logic [3:0]        head_cmd;
    logic [I_SIZE-1:0] head_addr;

    always_comb begin
        legal = 1'b0;
        case (in_cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign accept   = in_valid && !full;
    assign push     = accept && legal;
    // Reset suppresses dispatch in the reset cycle itself, before the state registers clear.
    assign out_valid = !rst && (state_q == RUN) && !empty;
    assign pop       = out_valid && out_ready;

    assign {head_cmd, head_addr} = mem_q[rd_ptr_q];

    // Data outputs read zero whenever nothing is queued.
    assign out_cmd   = empty ? 4'd0 : head_cmd;
    assign out_tag   = empty ? '0 : head_addr[I_SIZE-1 -: TAG_W];
    assign out_index = empty ? '0 : head_addr[D_SIZE +: INDEX_BITS];
    assign out_byte  = empty ? '0 : head_addr[D_SIZE-1:0];
    assign out_snoop = (out_cmd >= 4'd3) && (out_cmd <= 4'd6);
    assign bad_cmd   = bad_cmd_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_cmd, in_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            bad_cmd_q <= 1'b0;
            state_q   <= RUN;
        end else begin
            bad_cmd_q <= accept && !legal;
            state_q   <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (pop && out_cmd == 4'd8) begin
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (clr_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef CMD_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, snp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            snp_cnt_q <= '0;
        end else if (pop) begin
            case (out_cmd)
                4'd0, 4'd2:             rd_cnt_q  <= rd_cnt_q + 32'd1;
                4'd1:                   wr_cnt_q  <= wr_cnt_q + 32'd1;
                4'd3, 4'd4, 4'd5, 4'd6: snp_cnt_q <= snp_cnt_q + 32'd1;
                4'd8: begin
                    rd_cnt_q  <= '0;
                    wr_cnt_q  <= '0;
                    snp_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign snp_cnt = snp_cnt_q;
`else
    assign rd_cnt  = 32'd0;
    assign wr_cnt  = 32'd0;
    assign snp_cnt = 32'd0;
`endif

endmodule
